// File: rtl/axis_packetizer.sv
// Frames an unframed AXI-Stream beat stream into packets of cfg_len beats with tlast and per-packet tid.
// Latency: one cycle from input accept to m_axis_* when the output register is free.
// Backpressure: 2-entry skid (output + skid register); s_axis_tready is registered and drops only while the skid is full.
module axis_packetizer #(
    parameter int DATA_WIDTH = 32,
    parameter int TID_WIDTH  = 8,
    parameter int MAX_LEN    = 16,
    localparam int LEN_WIDTH = $clog2(MAX_LEN + 1)
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [TID_WIDTH-1:0]  m_axis_tid,
    output logic [15:0]           pkt_count
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] tdata;
        logic                  tlast;
        logic [TID_WIDTH-1:0]  tid;
    } beat_t;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t               state, state_nxt;
    logic [LEN_WIDTH-1:0] len_q, len_nxt;
    logic [LEN_WIDTH-1:0] cnt, cnt_nxt;
    logic [LEN_WIDTH-1:0] cfg_len_sat;
    logic                 flush_pending, flush_pending_nxt;
    logic                 beat_last;
    logic [TID_WIDTH-1:0] tid_cnt;
    logic [15:0]          pkt_cnt;

    logic                 in_rdy;
    logic                 accept;
    beat_t                in_beat, out_q, skid_q;
    logic                 out_vld, skid_vld, skid_vld_nxt;
    logic                 load_out;

    assign accept      = s_axis_tvalid && in_rdy;
    assign cfg_len_sat = (cfg_len == '0 || cfg_len > LEN_WIDTH'(MAX_LEN)) ? LEN_WIDTH'(MAX_LEN) : cfg_len;

    always_comb begin
        state_nxt         = state;
        len_nxt           = len_q;
        cnt_nxt           = cnt;
        flush_pending_nxt = flush_pending;
        beat_last         = 1'b0;
        case (state)
            IDLE: begin
                // flush is deliberately ignored here: there is no packet to terminate
                if (accept) begin
                    len_nxt = cfg_len_sat;
                    cnt_nxt = LEN_WIDTH'(1);
                    if (cfg_len_sat == LEN_WIDTH'(1)) begin
                        beat_last = 1'b1;
                    end else begin
                        state_nxt = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                if (accept) begin
                    beat_last = (cnt == len_q - LEN_WIDTH'(1)) || flush_pending || flush;
                    if (beat_last) begin
                        state_nxt         = IDLE;
                        cnt_nxt           = '0;
                        flush_pending_nxt = 1'b0;
                    end else begin
                        cnt_nxt = cnt + LEN_WIDTH'(1);
                    end
                end else if (flush) begin
                    flush_pending_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            len_q         <= '0;
            cnt           <= '0;
            flush_pending <= 1'b0;
            tid_cnt       <= '0;
            pkt_cnt       <= '0;
        end else begin
            state         <= state_nxt;
            len_q         <= len_nxt;
            cnt           <= cnt_nxt;
            flush_pending <= flush_pending_nxt;
            if (accept && beat_last) begin
                tid_cnt <= tid_cnt + TID_WIDTH'(1);
                pkt_cnt <= pkt_cnt + 16'd1;
            end
        end
    end

    // tid_cnt only moves on a tlast accept, so it is constant across a packet's beats
    assign in_beat = '{tdata: s_axis_tdata, tlast: beat_last, tid: tid_cnt};

    assign load_out = !out_vld || m_axis_tready;

    always_comb begin
        skid_vld_nxt = skid_vld;
        if (load_out) begin
            skid_vld_nxt = 1'b0;
        end else if (accept) begin
            skid_vld_nxt = 1'b1;
        end
    end

    // accept implies an empty skid, so the skid-to-output move never collides with a new beat
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_q    <= '0;
            out_vld  <= 1'b0;
            skid_q   <= '0;
            skid_vld <= 1'b0;
            in_rdy   <= 1'b0;
        end else begin
            if (load_out) begin
                if (skid_vld) begin
                    out_q   <= skid_q;
                    out_vld <= 1'b1;
                end else if (accept) begin
                    out_q   <= in_beat;
                    out_vld <= 1'b1;
                end else begin
                    out_vld <= 1'b0;
                end
            end else if (accept) begin
                skid_q <= in_beat;
            end
            skid_vld <= skid_vld_nxt;
            in_rdy   <= !skid_vld_nxt;
        end
    end

    assign s_axis_tready = in_rdy;
    assign m_axis_tvalid = out_vld;
    assign m_axis_tdata  = out_q.tdata;
    assign m_axis_tlast  = out_q.tlast;
    assign m_axis_tid    = out_q.tid;
    assign pkt_count     = pkt_cnt;

endmodule

// File: tb/tb_axis_packetizer.sv
// Directed bench for axis_packetizer: framing, length saturation, flush, random backpressure, async reset.
module tb_axis_packetizer;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [4:0]  cfg_len;
    logic        flush;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [7:0]  m_axis_tid;
    logic [15:0] pkt_count;

    always #5 aclk = ~aclk;

    axis_packetizer #(.DATA_WIDTH(32), .TID_WIDTH(8), .MAX_LEN(16)) dut (
        .aclk(aclk), .aresetn(aresetn), .cfg_len(cfg_len), .flush(flush),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid), .pkt_count(pkt_count)
    );

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic [7:0]  t;
        int          c;
    } beat_rec_t;

    beat_rec_t   outq[$];
    beat_rec_t   expq[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          occ = 0;
    bit          chk_en = 0;
    bit          rand_mode = 0;
    bit          acc_last = 0;
    bit          stall_prev = 0;
    logic [40:0] prev_beat = '0;
    logic [31:0] rd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, then move to just after the rising edge.
    task automatic cycle();
        bit emit;
        @(negedge aclk);
        cyc++;
        if (chk_en) begin
            chk("tready_vs_skid", s_axis_tready, occ != 2);
            if (stall_prev) begin
                chk("stall_valid", m_axis_tvalid, 1'b1);
                chk("stall_stable", {m_axis_tdata, m_axis_tlast, m_axis_tid}, prev_beat);
            end
        end
        stall_prev = m_axis_tvalid && !m_axis_tready;
        prev_beat  = {m_axis_tdata, m_axis_tlast, m_axis_tid};
        acc_last   = s_axis_tvalid && s_axis_tready;
        emit       = m_axis_tvalid && m_axis_tready;
        if (emit) outq.push_back('{m_axis_tdata, m_axis_tlast, m_axis_tid, cyc});
        occ = occ + int'(acc_last) - int'(emit);
        @(posedge aclk);
        #1;
        if (rand_mode) m_axis_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic push(input logic [31:0] d, input logic f, input logic el, input logic [7:0] et);
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        flush         = f;
        expq.push_back('{d, el, et, 0});
        for (int n = 0; ; n++) begin
            cycle();
            if (acc_last) break;
            if (n >= 100) begin
                checks++;
                failures++;
                $error("FAIL push_timeout observed=no_accept expected=accept data=%0h", d);
                break;
            end
        end
        flush = 1'b0;
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic check_stream(input string tag, input bit thru);
        int n;
        chk({tag, "_count"}, outq.size(), expq.size());
        n = (outq.size() < expq.size()) ? outq.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_data"}, outq[i].d, expq[i].d);
            chk({tag, "_last"}, outq[i].l, expq[i].l);
            chk({tag, "_tid"},  outq[i].t, expq[i].t);
            if (thru) chk({tag, "_cycle"}, outq[i].c - outq[0].c, i);
        end
        outq.delete();
        expq.delete();
    endtask

    initial begin
        aresetn       = 1'b0;
        cfg_len       = 5'd4;
        flush         = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        #12;
        chk("rst_tready", s_axis_tready, 1'b0);
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_tlast",  m_axis_tlast,  1'b0);
        chk("rst_tid",    m_axis_tid,    8'd0);
        chk("rst_tdata",  m_axis_tdata,  32'd0);
        chk("rst_pkt",    pkt_count,     16'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("tready_before_edge", s_axis_tready, 1'b0);
        @(posedge aclk);
        #1;
        chk("tready_after_edge", s_axis_tready, 1'b1);

        // len 4, continuous: tlast on every 4th beat, tid 0..2
        cfg_len = 5'd4;
        for (int i = 0; i < 12; i++) begin
            push(32'hA000 + i, 1'b0, (i % 4) == 3, 8'(i / 4));
            if (i == 0) begin
                chk("latency_valid", m_axis_tvalid, 1'b1);
                chk("latency_data",  m_axis_tdata,  32'hA000);
            end
        end
        idle(4);
        check_stream("len4", 1'b1);
        chk("len4_pkt", pkt_count, 16'd3);

        // len 0 and len 20 both saturate to 16; mid-packet cfg change must not matter
        cfg_len = 5'd0;
        for (int i = 0; i < 16; i++) push(32'hB000 + i, 1'b0, i == 15, 8'd3);
        cfg_len = 5'd20;
        for (int i = 0; i < 16; i++) begin
            if (i == 5) cfg_len = 5'd2;
            push(32'hC000 + i, 1'b0, i == 15, 8'd4);
        end
        idle(4);
        check_stream("sat", 1'b0);
        chk("sat_pkt", pkt_count, 16'd5);

        // len 1: every beat is its own packet
        cfg_len = 5'd1;
        for (int i = 0; i < 4; i++) push(32'hD000 + i, 1'b0, 1'b1, 8'(5 + i));
        idle(4);
        check_stream("len1", 1'b0);
        chk("len1_pkt", pkt_count, 16'd9);

        // flush: between beats, in IDLE, and coincident with an accept
        cfg_len = 5'd8;
        for (int i = 0; i < 3; i++) push(32'hE000 + i, 1'b0, 1'b0, 8'd9);
        s_axis_tvalid = 1'b0;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        push(32'hE003, 1'b0, 1'b1, 8'd9);
        for (int i = 0; i < 8; i++) push(32'hE100 + i, 1'b0, i == 7, 8'd10);
        idle(2);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        idle(1);
        for (int i = 0; i < 8; i++) push(32'hE200 + i, 1'b0, i == 7, 8'd11);
        push(32'hE300, 1'b0, 1'b0, 8'd12);
        push(32'hE301, 1'b0, 1'b0, 8'd12);
        push(32'hE302, 1'b1, 1'b1, 8'd12);
        idle(4);
        check_stream("flush", 1'b0);
        chk("flush_pkt", pkt_count, 16'd13);

        // random backpressure, 1000 beats of len 5
        cfg_len   = 5'd5;
        chk_en    = 1'b1;
        rand_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            rd = $urandom;
            push(rd, 1'b0, (i % 5) == 4, 8'(13 + i / 5));
        end
        s_axis_tvalid = 1'b0;
        rand_mode     = 1'b0;
        m_axis_tready = 1'b1;
        repeat (8) cycle();
        chk_en = 1'b0;
        check_stream("rand", 1'b0);
        chk("rand_pkt", pkt_count, 16'd213);

        // stall with skid full, then async reset mid-packet
        cfg_len       = 5'd4;
        m_axis_tready = 1'b0;
        push(32'hF000, 1'b0, 1'b0, 8'd213);
        push(32'hF001, 1'b0, 1'b0, 8'd213);
        chk("skid_full_tready", s_axis_tready, 1'b0);
        chk("stalled_valid",    m_axis_tvalid, 1'b1);
        chk("stalled_data",     m_axis_tdata,  32'hF000);
        s_axis_tvalid = 1'b0;
        #2;
        aresetn = 1'b0;
        #1;
        chk("arst_tready", s_axis_tready, 1'b0);
        chk("arst_tvalid", m_axis_tvalid, 1'b0);
        chk("arst_tlast",  m_axis_tlast,  1'b0);
        chk("arst_tid",    m_axis_tid,    8'd0);
        chk("arst_tdata",  m_axis_tdata,  32'd0);
        chk("arst_pkt",    pkt_count,     16'd0);
        outq.delete();
        expq.delete();
        occ        = 0;
        stall_prev = 0;
        @(negedge aclk);
        aresetn       = 1'b1;
        m_axis_tready = 1'b1;
        @(posedge aclk);
        #1;
        chk("rerelease_tready", s_axis_tready, 1'b1);
        for (int i = 0; i < 4; i++) push(32'h9000 + i, 1'b0, i == 3, 8'd0);
        idle(4);
        check_stream("post_rst", 1'b0);
        chk("post_rst_pkt", pkt_count, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
